// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: control-FSM status encodings, time limits and BCD helpers.
// Imported by stopwatch_tick_prescaler and stopwatch_time_counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_e;

  localparam int unsigned SEC_MAX               = 59;
  localparam int unsigned MAX_MIN_DEFAULT       = 99;
  localparam int unsigned TICKS_PER_SEC_DEFAULT = 100_000_000;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 7;
  localparam int unsigned OUT_W = 8;

  // Two packed BCD digits as presented on the readout bus.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic bcd2_t bcd_to_digits(input int unsigned v);
    bcd2_t r;
    r.tens  = 4'(v / 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
      r.tens  = v.tens;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
// The count is frozen while enable is low so a partial second survives a pause.
module stopwatch_tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick is combinational so the consumer can register it alongside the time update.
  assign tick = enable && !clear && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Elapsed-time counter (MAX_MIN:59 max) driven by the stopwatch control FSM.
// Define STOPWATCH_BCD_OUT_EN to keep and present seconds/minutes as packed BCD.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT,
  parameter int unsigned MAX_MIN       = MAX_MIN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_count,
  input  logic [1:0]       status,
  output logic [OUT_W-1:0] seconds,
  output logic [OUT_W-1:0] minutes,
  output logic             sec_tick,
  output logic             rollover
);

  logic clear_c;
  logic count_c;
  logic tick_c;
  logic sec_at_max_c;
  logic min_at_max_c;

  logic sec_tick_q;
  logic sec_tick_d;
  logic rollover_q;
  logic rollover_d;

  // Illegal status 11 holds like PAUSED; IDLE clears regardless of enable_count.
  assign clear_c = (status == ST_IDLE);
  assign count_c = enable_count && (status != ST_IDLE) && (status != ST_ILLEGAL);

  stopwatch_tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_c),
    .enable (count_c),
    .tick   (tick_c)
  );

`ifdef STOPWATCH_BCD_OUT_EN
  localparam bcd2_t SEC_MAX_BCD = bcd_to_digits(SEC_MAX);
  localparam bcd2_t MIN_MAX_BCD = bcd_to_digits(MAX_MIN);

  bcd2_t sec_q;
  bcd2_t sec_d;
  bcd2_t min_q;
  bcd2_t min_d;

  assign sec_at_max_c = (sec_q == SEC_MAX_BCD);
  assign min_at_max_c = (min_q == MIN_MAX_BCD);

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (clear_c) begin
      sec_d = '0;
      min_d = '0;
    end else if (tick_c) begin
      if (sec_at_max_c) begin
        sec_d = '0;
        min_d = min_at_max_c ? '0 : bcd_inc(min_q);
      end else begin
        sec_d = bcd_inc(sec_q);
      end
    end
  end

  assign seconds = sec_q;
  assign minutes = min_q;
`else
  logic [SEC_W-1:0] sec_q;
  logic [SEC_W-1:0] sec_d;
  logic [MIN_W-1:0] min_q;
  logic [MIN_W-1:0] min_d;

  assign sec_at_max_c = (sec_q == SEC_W'(SEC_MAX));
  assign min_at_max_c = (min_q == MIN_W'(MAX_MIN));

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (clear_c) begin
      sec_d = '0;
      min_d = '0;
    end else if (tick_c) begin
      if (sec_at_max_c) begin
        sec_d = '0;
        min_d = min_at_max_c ? '0 : min_q + MIN_W'(1);
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end
  end

  assign seconds = {{(OUT_W - SEC_W){1'b0}}, sec_q};
  assign minutes = {{(OUT_W - MIN_W){1'b0}}, min_q};
`endif

  // Event pulses line up with the edge that commits the new time.
  always_comb begin
    sec_tick_d = 1'b0;
    rollover_d = 1'b0;
    if (!clear_c && tick_c) begin
      sec_tick_d = 1'b1;
      rollover_d = sec_at_max_c && min_at_max_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q      <= '0;
      min_q      <= '0;
      sec_tick_q <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      sec_tick_q <= sec_tick_d;
      rollover_q <= rollover_d;
    end
  end

  assign sec_tick = sec_tick_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Self-checking bench for stopwatch_time_counter (TICKS_PER_SEC=4, MAX_MIN=2).
// Reference model tracks enabled cycles since clear and derives time by division.
module tb_stopwatch_time_counter;
  import stopwatch_pkg::*;

  localparam int unsigned T  = 4;
  localparam int unsigned MM = 2;
  localparam longint WRAP = 60 * (MM + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_count = 1'b0;
  logic [1:0] status = 2'b00;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic       sec_tick;
  logic       rollover;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_time_counter #(
    .TICKS_PER_SEC (T),
    .MAX_MIN       (MM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_count (enable_count),
    .status       (status),
    .seconds      (seconds),
    .minutes      (minutes),
    .sec_tick     (sec_tick),
    .rollover     (rollover)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input longint v);
`ifdef STOPWATCH_BCD_OUT_EN
    return 8'(((v / 10) << 4) | (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed enabled cycles since last clear/reset.
  longint e_q = 0;
  longint e_n;
  logic   m_tick = 1'b0;
  logic   m_roll = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= 0;
      m_tick <= 1'b0;
      m_roll <= 1'b0;
    end else if (status == 2'b00) begin
      e_q    <= 0;
      m_tick <= 1'b0;
      m_roll <= 1'b0;
    end else if (enable_count && status != 2'b11) begin
      e_n     = e_q + 1;
      e_q    <= e_n;
      m_tick <= (e_n % T) == 0;
      m_roll <= ((e_n % T) == 0) && (((e_n / T) % WRAP) == 0);
    end else begin
      m_tick <= 1'b0;
      m_roll <= 1'b0;
    end
  end

  // Continuous compare against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_seconds", seconds, enc(((e_q / T) % WRAP) % 60));
      chk("model_minutes", minutes, enc(((e_q / T) % WRAP) / 60));
      chk("model_sec_tick", 8'(sec_tick), 8'(m_tick));
      chk("model_rollover", 8'(rollover), 8'(m_roll));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] st, input logic en);
    status       = st;
    enable_count = en;
  endtask

  int ticks_seen;
  int rolls_seen;
  int run_len;
  int r;

  initial begin
    // Reset state
    #12;
    chk("reset_seconds", seconds, 8'd0);
    chk("reset_minutes", minutes, 8'd0);
    chk("reset_sec_tick", 8'(sec_tick), 8'd0);
    step(1);
    rst_n = 1'b1;

    // First tick exactly T enabled cycles after start
    drive(ST_RUNNING, 1'b1);
    step(3);
    chk("first_no_tick", 8'(sec_tick), 8'd0);
    chk("first_sec0", seconds, enc(0));
    step(1);
    chk("first_tick", 8'(sec_tick), 8'd1);
    chk("first_sec1", seconds, enc(1));
    chk("first_min0", minutes, enc(0));
    step(1);
    chk("tick_single_cycle", 8'(sec_tick), 8'd0);

    // 60 ticks from 00:00
    drive(ST_IDLE, 1'b0);
    step(1);
    chk("clear_sec", seconds, enc(0));
    drive(ST_RUNNING, 1'b1);
    ticks_seen = 0;
    rolls_seen = 0;
    for (int i = 0; i < 240; i++) begin
      step(1);
      ticks_seen += int'(sec_tick);
      rolls_seen += int'(rollover);
    end
    chk("min1_sec", seconds, enc(0));
    chk("min1_min", minutes, enc(1));
    chk("tick_count_60", 8'(ticks_seen), 8'd60);
    chk("no_roll_60", 8'(rolls_seen), 8'd0);

    // Pause preserves the sub-second fraction
    step(2);
    drive(ST_PAUSED, 1'b0);
    ticks_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      ticks_seen += int'(sec_tick);
    end
    chk("pause_no_tick", 8'(ticks_seen), 8'd0);
    chk("pause_sec", seconds, enc(0));
    chk("pause_min", minutes, enc(1));
    drive(ST_RUNNING, 1'b1);
    step(1);
    chk("resume_no_tick", 8'(sec_tick), 8'd0);
    step(1);
    chk("resume_tick", 8'(sec_tick), 8'd1);
    chk("resume_sec", seconds, enc(1));

    // Run to MAX_MIN:59 then wrap
    drive(ST_IDLE, 1'b0);
    step(1);
    drive(ST_RUNNING, 1'b1);
    step(179 * 4);
    chk("at_max_sec", seconds, enc(59));
`ifdef STOPWATCH_BCD_OUT_EN
    chk("sec59_literal", seconds, 8'h59);
`else
    chk("sec59_literal", seconds, 8'd59);
`endif
    chk("at_max_min", minutes, enc(2));
    step(3);
    chk("pre_wrap_no_roll", 8'(rollover), 8'd0);
    step(1);
    chk("wrap_roll", 8'(rollover), 8'd1);
    chk("wrap_tick", 8'(sec_tick), 8'd1);
    chk("wrap_sec", seconds, 8'd0);
    chk("wrap_min", minutes, 8'd0);
    step(1);
    chk("roll_single_cycle", 8'(rollover), 8'd0);

    // Clear at 01:30 mid-second also resets the prescaler
    drive(ST_IDLE, 1'b0);
    step(1);
    drive(ST_RUNNING, 1'b1);
    step(90 * 4 + 2);
    chk("at_0130_min", minutes, enc(1));
    chk("at_0130_sec", seconds, enc(30));
    drive(ST_IDLE, 1'b1);
    step(1);
    chk("idle_sec", seconds, 8'd0);
    chk("idle_min", minutes, 8'd0);
    drive(ST_RUNNING, 1'b1);
    step(3);
    chk("restart_no_tick", 8'(sec_tick), 8'd0);
    step(1);
    chk("restart_tick", 8'(sec_tick), 8'd1);
    chk("restart_sec", seconds, enc(1));

    // Illegal status holds even with enable high
    drive(ST_ILLEGAL, 1'b1);
    step(8);
    chk("illegal_hold_sec", seconds, enc(1));

    // Asynchronous reset between edges
    drive(ST_RUNNING, 1'b1);
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sec", seconds, 8'd0);
    chk("async_rst_min", minutes, 8'd0);
    chk("async_rst_tick", 8'(sec_tick), 8'd0);
    step(2);
    rst_n = 1'b1;

    // Randomized bursts of control states
    for (int b = 0; b < 150; b++) begin
      r = int'($urandom_range(0, 31));
      if (r == 0)       drive(ST_IDLE, 1'($urandom_range(0, 1)));
      else if (r < 5)   drive(ST_PAUSED, 1'($urandom_range(0, 1)));
      else if (r < 7)   drive(ST_ILLEGAL, 1'($urandom_range(0, 1)));
      else              drive(ST_RUNNING, (r == 7) ? 1'b0 : 1'b1);
      run_len = int'($urandom_range(1, 40));
      step(run_len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- Downstream of the stopwatch control FSM; consumes its enable_count and status outputs.
- Divides clk into a 1-second tick and keeps elapsed time as minutes (0-99) and seconds (0-59).
- Feeds the display/readout stage with registered time values and single-cycle event pulses.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per second; legal range 2 to 2^32-1.
- MAX_MIN, 99, highest minute value before wrap; legal range 1 to 99.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- enable_count  input  1  count enable from the control FSM (high only in RUNNING).
- status  input  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 illegal.
- seconds  output  8  elapsed seconds; encoding set by the optional feature.
- minutes  output  8  elapsed minutes; encoding set by the optional feature.
- sec_tick  output  1  one-cycle pulse on each seconds increment.
- rollover  output  1  one-cycle pulse when time wraps MAX_MIN:59 -> 00:00.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler=0, seconds=0, minutes=0, sec_tick=0, rollover=0.
- All outputs are registered. No combinational path from any input to any output.
- Priority per cycle: clear > count > hold.
- Clear: status==IDLE forces prescaler, seconds and minutes to 0 on the next edge. sec_tick and rollover are 0. Clear holds while IDLE persists.
- Count: enable_count=1 and status!=IDLE.
  - Prescaler increments once per cycle.
  - When prescaler==TICKS_PER_SEC-1, the prescaler goes to 0 on that edge, seconds increments, and sec_tick=1 for that single cycle.
  - The first sec_tick after a clear occurs exactly TICKS_PER_SEC enabled cycles after enable_count rises.
- Hold: enable_count=0 (PAUSED or illegal 11). Prescaler, seconds and minutes are frozen. The sub-second fraction is preserved, so resuming completes the partial second first.
- seconds==59 at tick: seconds goes to 0 and minutes increments, in the same edge.
- minutes==MAX_MIN and seconds==59 at tick: both go to 0, and rollover=1 together with sec_tick=1 for one cycle.
- enable_count=1 with status==IDLE (illegal combination): clear wins.
- status==11: treated as hold regardless of enable_count. No clear.
- Prescaler width is $clog2(TICKS_PER_SEC). Seconds and minutes are held internally as 6-bit and 7-bit binary.

Optional Feature:
- Macro: STOPWATCH_BCD_OUT_EN.
- Defined: seconds and minutes are driven as two packed BCD digits, tens in [7:4] and units in [3:0]. Example: 59 s reads 8'h59.
  - Digits are kept natively in BCD: units wraps 9->0 and carries into tens. No binary-to-BCD conversion stage.
  - Output timing is identical to the binary build.
- Undefined: seconds and minutes are unsigned binary, zero-extended to 8 bits. Example: 59 s reads 8'd59.

Decomposition:
- Shared package stopwatch_pkg holds:
  - status encodings ST_IDLE=2'b00, ST_RUNNING=2'b01, ST_PAUSED=2'b10, shared with the control FSM;
  - SEC_MAX=59;
  - the default TICKS_PER_SEC.
- One sub-module: stopwatch_tick_prescaler.
  - Inputs: clk, rst_n, clear, enable.
  - Output: tick, asserted combinationally at terminal count and enable.
  - Parameter: TICKS_PER_SEC.
- The time registers and wrap logic stay in the top module.

Test Plan (TICKS_PER_SEC=4, MAX_MIN=2):
- Reset, then status=RUNNING with enable_count=1 for 4 cycles -> sec_tick pulses once on the 4th edge; seconds=1, minutes=0.
- Run 60 ticks (240 cycles) from 00:00 -> seconds=0, minutes=1; sec_tick count=60; no rollover.
- Run 2 cycles, pause (status=PAUSED, enable=0) for 10 cycles, then resume -> first sec_tick arrives 2 enabled cycles after resume; time frozen during the pause.
- Run to 02:59 then one more tick -> 00:00 with rollover=1 and sec_tick=1 in the same single cycle.
- At 01:30, status=IDLE for 1 cycle -> 00:00 next edge with prescaler cleared; restart gives first tick after exactly 4 enabled cycles.
- Assert rst_n low mid-second, asynchronously between edges -> outputs go to 0 immediately without a clock edge. With STOPWATCH_BCD_OUT_EN defined, 59 s reads 8'h59.
